// File: rtl/qkv_request_scheduler.sv
// qkv_request_scheduler
// Round-robin front end for one shared QKV projection datapath. One request is
// in flight at a time: the granted vector is held on gen_vector, the generator
// results are captured after GEN_LAT cycles, and they are returned with the
// requester id over a valid/ready response port. Overflowed responses are
// counted in a saturating 16-bit counter.
module qkv_request_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int VEC_W   = 256,
  parameter int OUT_W   = 192,
  parameter int GEN_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_vector,
  output logic [VEC_W-1:0]         gen_vector,
  input  logic [OUT_W-1:0]         gen_q,
  input  logic [OUT_W-1:0]         gen_k,
  input  logic [OUT_W-1:0]         gen_v,
  input  logic [2:0]               gen_overflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [OUT_W-1:0]         rsp_q,
  output logic [OUT_W-1:0]         rsp_k,
  output logic [OUT_W-1:0]         rsp_v,
  output logic [2:0]               rsp_overflow,
  output logic [15:0]              ovf_count,
  input  logic                     ovf_clear,
  output logic                     busy
);

  localparam int          CNT_W = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1;
  localparam int unsigned NREQ  = NUM_REQ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [OUT_W-1:0]   rsp_q_q, rsp_q_d;
  logic [OUT_W-1:0]   rsp_k_q, rsp_k_d;
  logic [OUT_W-1:0]   rsp_v_q, rsp_v_d;
  logic [2:0]         rsp_ovf_q, rsp_ovf_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d;

  logic [2*NUM_REQ-1:0] rot;
  int unsigned          off;
  int unsigned          gsum;
  int unsigned          nsum;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      grant_next;
  logic [NUM_REQ-1:0]   grant_oh;

  // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then rotate the offset back into an index.
  always_comb begin
    rot = {req_valid, req_valid} >> rr_ptr_q;
    off = 0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (rot[i-1]) off = i - 1;
    end
    grant_valid = |req_valid;
    gsum = 32'(rr_ptr_q) + off;
    if (gsum >= NREQ) gsum = gsum - NREQ;
    nsum = (gsum + 1 == NREQ) ? 0 : gsum + 1;
    grant_idx  = ID_W'(gsum);
    grant_next = ID_W'(nsum);
    grant_oh   = NUM_REQ'(1) << grant_idx;
  end

  // Grant is offered only while idle; gated by rst so it reads zero during reset.
  assign req_ready = (state_q == IDLE && grant_valid && !rst) ? grant_oh : '0;

  assign gen_vector   = vec_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = id_q;
  assign rsp_q        = rsp_q_q;
  assign rsp_k        = rsp_k_q;
  assign rsp_v        = rsp_v_q;
  assign rsp_overflow = rsp_ovf_q;
  assign ovf_count    = ovf_cnt_q;
  assign busy         = (state_q != IDLE);

  // Next-state and datapath capture for the single in-flight transaction.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    vec_d      = vec_q;
    id_d       = id_q;
    rsp_q_d    = rsp_q_q;
    rsp_k_d    = rsp_k_q;
    rsp_v_d    = rsp_v_q;
    rsp_ovf_d  = rsp_ovf_q;
    ovf_cnt_d  = ovf_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          vec_d      = req_vector[VEC_W*grant_idx +: VEC_W];
          id_d       = grant_idx;
          rr_ptr_d   = grant_next;
          wait_cnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (wait_cnt_q == CNT_W'(GEN_LAT - 1)) begin
          rsp_q_d   = gen_q;
          rsp_k_d   = gen_k;
          rsp_v_d   = gen_v;
          rsp_ovf_d = gen_overflow;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (|rsp_ovf_q && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ovf_clear) ovf_cnt_d = '0;
  end

  // State registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      vec_q      <= '0;
      id_q       <= '0;
      rsp_q_q    <= '0;
      rsp_k_q    <= '0;
      rsp_v_q    <= '0;
      rsp_ovf_q  <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      vec_q      <= vec_d;
      id_q       <= id_d;
      rsp_q_q    <= rsp_q_d;
      rsp_k_q    <= rsp_k_d;
      rsp_v_q    <= rsp_v_d;
      rsp_ovf_q  <= rsp_ovf_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

endmodule

// File: tb/tb_qkv_request_scheduler.sv
// Directed testbench for qkv_request_scheduler (NUM_REQ=3, GEN_LAT=1).
module tb_qkv_request_scheduler;

  localparam int NUM_REQ = 3;
  localparam int VEC_W   = 256;
  localparam int OUT_W   = 192;
  localparam int GEN_LAT = 1;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*VEC_W-1:0] req_vector;
  logic [VEC_W-1:0]         gen_vector;
  logic [OUT_W-1:0]         gen_q, gen_k, gen_v;
  logic [2:0]               gen_overflow;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [OUT_W-1:0]         rsp_q, rsp_k, rsp_v;
  logic [2:0]               rsp_overflow;
  logic [15:0]              ovf_count;
  logic                     ovf_clear;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Generator model: Q lane0 = vector lane0, K lane0 = vector lane1, V = low OUT_W bits.
  assign gen_q = OUT_W'(gen_vector[15:0]);
  assign gen_k = OUT_W'(gen_vector[31:16]);
  assign gen_v = gen_vector[OUT_W-1:0];

  qkv_request_scheduler #(
    .NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .OUT_W(OUT_W), .GEN_LAT(GEN_LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vector(req_vector),
    .gen_vector(gen_vector), .gen_q(gen_q), .gen_k(gen_k), .gen_v(gen_v),
    .gen_overflow(gen_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_k(rsp_k), .rsp_v(rsp_v), .rsp_overflow(rsp_overflow),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Requester i gets lane0 = base ^ i, all other bits zero.
  task automatic set_vectors(input logic [15:0] base);
    req_vector = '0;
    for (int i = 0; i < NUM_REQ; i++) req_vector[VEC_W*i +: 16] = base ^ 16'(i);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req_valid = '0; rsp_ready = 1'b0; ovf_clear = 1'b0; gen_overflow = '0;
    set_vectors(16'h0000);
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  // Runs one full transaction with rsp_ready high; returns served id and rsp_q lane0.
  task automatic do_txn(input logic [2:0] valid, input logic [15:0] base, input logic [2:0] ovf,
                        input logic clr, output logic [1:0] id, output logic [15:0] q);
    int n;
    id = '0; q = '0;
    set_vectors(base);
    req_valid = valid; gen_overflow = ovf; rsp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin tick; n++; end
    checks++;
    if (req_ready == '0) begin
      errors++; $display("FAIL txn_grant_timeout: req_ready=%b required nonzero", req_ready);
      req_valid = '0; return;
    end
    tick;
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick; n++; end
    checks++;
    if (!rsp_valid) begin
      errors++; $display("FAIL txn_rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      return;
    end
    id = rsp_id; q = rsp_q[15:0];
    ovf_clear = clr;
    tick;
    ovf_clear = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 3'b111; rsp_ready = 1'b0; ovf_clear = 1'b0; gen_overflow = '0;
    set_vectors(16'h4440);
    tick;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (gen_vector !== '0) begin errors++; $display("FAIL reset_gen_vector: got %h want 0", gen_vector); end
    checks++; if (ovf_count !== 16'h0000) begin errors++; $display("FAIL reset_ovf_count: got %h want 0", ovf_count); end
    checks++; if (rsp_q !== '0 || rsp_id !== '0 || rsp_overflow !== '0) begin
      errors++; $display("FAIL reset_rsp_regs: q=%h id=%0d ovf=%b want zeros", rsp_q, rsp_id, rsp_overflow); end
    req_valid = '0;
    rst = 1'b0;
    tick;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_after: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_single;
    req_vector = '0;
    req_vector[VEC_W*1 +: 16] = 16'h0100;
    req_valid = 3'b010; rsp_ready = 1'b1; gen_overflow = '0;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_grant: got %b want 010", req_ready); end
    tick;  // accept edge
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL single_issue: busy=%b rsp_valid=%b req_ready=%b want 1 0 000", busy, rsp_valid, req_ready); end
    checks++; if (gen_vector[15:0] !== 16'h0100) begin errors++; $display("FAIL single_gen_vector: got %h want 0100", gen_vector[15:0]); end
    tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_resp: rsp_valid=%b rsp_id=%0d busy=%b want 1 1 1", rsp_valid, rsp_id, busy); end
    checks++; if (rsp_q[15:0] !== 16'h0100 || rsp_k !== '0) begin
      errors++; $display("FAIL single_rsp_q: q=%h k=%h want 0100 0", rsp_q[15:0], rsp_k); end
    tick;  // handshake edge
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || gen_vector[15:0] !== 16'h0100) begin
      errors++; $display("FAIL single_done: busy=%b rsp_valid=%b gen=%h want 0 0 0100", busy, rsp_valid, gen_vector[15:0]); end
  endtask

  task automatic test_round_robin;
    int exp_id;
    apply_reset;
    set_vectors(16'hA000);
    req_valid = 3'b111; rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      exp_id = (cyc / 3) % 3;
      checks++; if ($countones(req_ready) > 1) begin errors++; $display("FAIL rr_multi_hot: cyc %0d got %b", cyc, req_ready); end
      if (cyc % 3 == 0) begin
        checks++; if (req_ready !== 3'(1 << exp_id)) begin
          errors++; $display("FAIL rr_grant: cyc %0d got %b want %b", cyc, req_ready, 3'(1 << exp_id)); end
      end else begin
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rr_no_grant: cyc %0d got %b want 000", cyc, req_ready); end
      end
      if (cyc % 3 == 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_q[15:0] !== (16'hA000 ^ 16'(exp_id))) begin
          errors++; $display("FAIL rr_resp: cyc %0d valid=%b id=%0d q=%h want 1 %0d %h", cyc, rsp_valid, rsp_id,
                             rsp_q[15:0], exp_id, 16'hA000 ^ 16'(exp_id)); end
      end
      tick;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    // rr_ptr is 0 after six round-robin grants
    set_vectors(16'h1230);
    req_valid = 3'b001; rsp_ready = 1'b0; gen_overflow = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_grant0: got %b want 001", req_ready); end
    tick;
    req_valid = 3'b110;
    set_vectors(16'hFFF0);
    #1;
    checks++; if (gen_vector[15:0] !== 16'h1230) begin errors++; $display("FAIL bp_gen_hold: got %h want 1230", gen_vector[15:0]); end
    tick;
    gen_overflow = 3'b000;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_q[15:0] !== 16'h1230 || rsp_overflow !== 3'b010) begin
        errors++; $display("FAIL bp_stable: c %0d valid=%b id=%0d q=%h ovf=%b want 1 0 1230 010", c, rsp_valid, rsp_id,
                           rsp_q[15:0], rsp_overflow); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_no_grant: c %0d got %b want 000", c, req_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %b want 1", rsp_valid); end
    tick;  // handshake edge
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_resume_grant: got %b want 010", req_ready); end
    tick;
    req_valid = '0;
    tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_q[15:0] !== 16'hFFF1) begin
      errors++; $display("FAIL bp_next_resp: valid=%b id=%0d q=%h want 1 1 fff1", rsp_valid, rsp_id, rsp_q[15:0]); end
    tick;
  endtask

  task automatic test_overflow;
    logic [1:0]  id;
    logic [15:0] q;
    apply_reset;
    do_txn(3'b001, 16'h0010, 3'b101, 1'b0, id, q);
    do_txn(3'b001, 16'h0020, 3'b000, 1'b0, id, q);
    checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL ovf_after_clean: got %0d want 1", ovf_count); end
    do_txn(3'b001, 16'h0030, 3'b101, 1'b0, id, q);
    checks++; if (ovf_count !== 16'd2) begin errors++; $display("FAIL ovf_count2: got %0d want 2", ovf_count); end
    force dut.ovf_cnt_q = 16'hFFFF;
    #1;
    release dut.ovf_cnt_q;
    #1;
    do_txn(3'b001, 16'h0040, 3'b101, 1'b0, id, q);
    checks++; if (ovf_count !== 16'hFFFF) begin errors++; $display("FAIL ovf_saturate: got %h want ffff", ovf_count); end
    ovf_clear = 1'b1;
    tick;
    ovf_clear = 1'b0;
    checks++; if (ovf_count !== 16'h0000) begin errors++; $display("FAIL ovf_clear_idle: got %h want 0", ovf_count); end
    do_txn(3'b001, 16'h0050, 3'b001, 1'b0, id, q);
    checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL ovf_after_clear: got %0d want 1", ovf_count); end
    do_txn(3'b001, 16'h0060, 3'b100, 1'b1, id, q);
    checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL ovf_clear_wins: got %0d want 0", ovf_count); end
  endtask

  task automatic test_reset_mid;
    logic [1:0]  id;
    logic [15:0] q;
    do_txn(3'b001, 16'h5550, 3'b101, 1'b0, id, q);  // ovf_count=1, rr_ptr=1
    set_vectors(16'h7770);
    req_valid = 3'b010; rsp_ready = 1'b1; gen_overflow = 3'b111;
    #1;
    tick;  // accept, now ISSUE
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL mid_rst_ctrl: busy=%b valid=%b ready=%b want 0 0 000", busy, rsp_valid, req_ready); end
    checks++; if (gen_vector !== '0 || rsp_q !== '0 || rsp_id !== '0 || rsp_overflow !== '0 || ovf_count !== '0) begin
      errors++; $display("FAIL mid_rst_data: gen=%h q=%h id=%0d ovf=%b cnt=%h want zeros", gen_vector[15:0], rsp_q[15:0],
                         rsp_id, rsp_overflow, ovf_count); end
    tick;
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_no_rsp: c %0d valid=%b busy=%b want 0 0", c, rsp_valid, busy); end
    end
    do_txn(3'b111, 16'h8880, 3'b000, 1'b0, id, q);
    checks++; if (id !== 2'd0 || q !== 16'h8880) begin errors++; $display("FAIL mid_restart_id: id=%0d q=%h want 0 8880", id, q); end
  endtask

  task automatic test_fairness;
    logic [1:0]  id;
    logic [15:0] q;
    apply_reset;
    do_txn(3'b100, 16'h0B00, 3'b000, 1'b0, id, q);
    checks++; if (id !== 2'd2 || q !== 16'h0B02) begin errors++; $display("FAIL fair_first: id=%0d q=%h want 2 0b02", id, q); end
    req_valid = 3'b101;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL fair_grant0: got %b want 001", req_ready); end
    do_txn(3'b101, 16'h0C00, 3'b000, 1'b0, id, q);
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL fair_second: id=%0d want 0", id); end
    do_txn(3'b101, 16'h0D00, 3'b000, 1'b0, id, q);
    checks++; if (id !== 2'd2 || q !== 16'h0D02) begin errors++; $display("FAIL fair_third: id=%0d q=%h want 2 0d02", id, q); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_overflow;
    test_reset_mid;
    test_fairness;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
